// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
//   pc_sel_t : next-PC selection encoding driven by decode/branch resolution.
//   state_t  : sequencer FSM states.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_CALL   = 3'd2,
        PC_RET    = 3'd3,
        PC_TRAP   = 3'd4,
        PC_HALT   = 3'd5
    } pc_sel_t;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/ras_stack.sv
// ras_stack: return-address stack kept as a circular buffer with a top pointer.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write push_data at the top (overwrites oldest when full)
//   pop        remove the top entry (ignored when empty)
//   push_data  address to store
//   pop_data   current top entry (valid when count > 0)
//   count      number of live entries, saturates at RAS_DEPTH
//   overflow   sticky: a push happened while full
// push and pop are never asserted together by the sequencer.
module ras_stack #(
    parameter int RAS_DEPTH  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        push_data,
    output logic [ADDR_WIDTH-1:0]        pop_data,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         overflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    // ptr_q addresses the next free slot; the top entry lives at ptr_q-1.
    // Depth is a power of two so the pointer wraps naturally.
    logic [PW-1:0]         ptr_q;
    logic [PW:0]           count_q;
    logic                  overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (push) begin
            ptr_q <= ptr_q + 1'b1;
            if (count_q == FULL) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop && (count_q != '0)) begin
            ptr_q   <= ptr_q - 1'b1;
            count_q <= count_q - 1'b1;
        end
    end

    // Contents are not cleared on reset; count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[ptr_q - 1'b1];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program-counter sequencer with valid/ready output,
// return-address stack and target alignment checking.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   pc_sel         next-PC selection (pc_sel_t; 6,7 hold)
//   target_addr    branch/call target, fallback for a return on empty stack
//   pc_ready       fetch accepts pc_out this cycle
//   pc_out         current fetch address
//   pc_valid       pc_out valid for fetch
//   ras_count      live return-address stack entries
//   ras_overflow   sticky: a call overwrote the oldest stack entry
//   ret_underflow  one-cycle pulse: return with empty stack
//   misalign_err   one-cycle pulse: misaligned target redirected to TRAP_VEC
//   halted         sequencer is in S_HALT
//   dbg_state      current FSM state, for observation only
// Handshake: pc_out is offered while pc_valid is high; the PC advances only on
// a cycle where pc_valid && pc_ready, and pc_out/pc_sel effects hold otherwise.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_BYTES = 4,
    parameter int                    RAS_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VEC    = ADDR_WIDTH'('h100)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  pc_sel,
    input  logic [ADDR_WIDTH-1:0]       target_addr,
    input  logic                        pc_ready,
    output logic [ADDR_WIDTH-1:0]       pc_out,
    output logic                        pc_valid,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ret_underflow,
    output logic                        misalign_err,
    output logic                        halted,
    output state_t                      dbg_state
);
    localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INSTR_BYTES);
    // Low address bits that must be zero; all-zero mask when INSTR_BYTES==1.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  pc_valid_q;
    logic                  ret_underflow_q;
    logic                  misalign_q;
    logic                  halted_q;

    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  misalign_d;
    logic                  underflow_d;
    logic                  halt_d;
    logic                  sel_push;
    logic                  sel_pop;
    logic                  advance;
    logic                  target_ok;

    logic [ADDR_WIDTH-1:0]      ras_pop_data;
    logic [$clog2(RAS_DEPTH):0] ras_count_w;
    logic                       ras_overflow_w;

    assign advance   = (state_q == S_RUN) && pc_valid_q && pc_ready;
    assign target_ok = (target_addr & ALIGN_MASK) == '0;

    // Next-PC selection; only takes effect on an advance.
    always_comb begin
        pc_d        = pc_q;
        misalign_d  = 1'b0;
        underflow_d = 1'b0;
        halt_d      = 1'b0;
        sel_push    = 1'b0;
        sel_pop     = 1'b0;
        case (pc_sel_t'(pc_sel))
            PC_SEQ: pc_d = pc_q + INC;
            PC_BRANCH: begin
                if (target_ok) begin
                    pc_d = target_addr;
                end else begin
                    pc_d       = TRAP_VEC;
                    misalign_d = 1'b1;
                end
            end
            PC_CALL: begin
                // A rejected call leaves the stack untouched.
                if (target_ok) begin
                    pc_d     = target_addr;
                    sel_push = 1'b1;
                end else begin
                    pc_d       = TRAP_VEC;
                    misalign_d = 1'b1;
                end
            end
            PC_RET: begin
                if (ras_count_w != '0) begin
                    pc_d    = ras_pop_data;
                    sel_pop = 1'b1;
                end else begin
                    underflow_d = 1'b1;
                    if (target_ok) begin
                        pc_d = target_addr;
                    end else begin
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end
                end
            end
            PC_TRAP: pc_d = TRAP_VEC;
            PC_HALT: halt_d = 1'b1;
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_BOOT;
            pc_q            <= RESET_ADDR;
            pc_valid_q      <= 1'b0;
            ret_underflow_q <= 1'b0;
            misalign_q      <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            ret_underflow_q <= 1'b0;
            misalign_q      <= 1'b0;
            case (state_q)
                S_BOOT: begin
                    state_q    <= S_RUN;
                    pc_valid_q <= 1'b1;
                end
                S_RUN: begin
                    if (advance) begin
                        pc_q            <= pc_d;
                        ret_underflow_q <= underflow_d;
                        misalign_q      <= misalign_d;
                        if (halt_d) begin
                            state_q    <= S_HALT;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b1;
                end
                default: begin
                    state_q    <= S_BOOT;
                    pc_valid_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    ras_stack #(
        .RAS_DEPTH  (RAS_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (advance && sel_push),
        .pop       (advance && sel_pop),
        .push_data (pc_q + INC),
        .pop_data  (ras_pop_data),
        .count     (ras_count_w),
        .overflow  (ras_overflow_w)
    );

    assign pc_out        = pc_q;
    assign pc_valid      = pc_valid_q;
    assign ras_count     = ras_count_w;
    assign ras_overflow  = ras_overflow_w;
    assign ret_underflow = ret_underflow_q;
    assign misalign_err  = misalign_q;
    assign halted        = halted_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          AW = 32;
    localparam int          IB = 4;
    localparam int          RD = 8;
    localparam logic [31:0] RA = 32'h0;
    localparam logic [31:0] TV = 32'h100;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_sel;
    logic [31:0] target_addr;
    logic        pc_ready;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ret_underflow;
    logic        misalign_err;
    logic        halted;
    state_t      dbg_state;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_WIDTH  (AW),
        .INSTR_BYTES (IB),
        .RAS_DEPTH   (RD),
        .RESET_ADDR  (RA),
        .TRAP_VEC    (TV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .target_addr   (target_addr),
        .pc_ready      (pc_ready),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ret_underflow (ret_underflow),
        .misalign_err  (misalign_err),
        .halted        (halted),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_pc;
    bit          m_booting, m_valid, m_halted, m_ovf, m_uf, m_mis;
    logic [31:0] exp_q[$];   // return addresses, newest at the back

    function automatic bit misaligned(input logic [31:0] a);
        return (a % IB) != 0;
    endfunction

    task automatic model_edge(input logic r, input logic [2:0] sel,
                              input logic [31:0] tgt, input logic rdy);
        if (r) begin
            m_pc = RA; m_booting = 1; m_valid = 0; m_halted = 0;
            m_ovf = 0; m_uf = 0; m_mis = 0;
            exp_q.delete();
            return;
        end
        m_uf = 0; m_mis = 0;
        if (m_booting) begin
            m_booting = 0; m_valid = 1;
            return;
        end
        if (!(m_valid && rdy)) return;
        case (sel)
            3'd0: m_pc = m_pc + 32'(IB);
            3'd1: if (misaligned(tgt)) begin m_pc = TV; m_mis = 1; end
                  else m_pc = tgt;
            3'd2: if (misaligned(tgt)) begin m_pc = TV; m_mis = 1; end
                  else begin
                      exp_q.push_back(m_pc + 32'(IB));
                      if (exp_q.size() > RD) begin
                          void'(exp_q.pop_front());
                          m_ovf = 1;
                      end
                      m_pc = tgt;
                  end
            3'd3: if (exp_q.size() > 0) m_pc = exp_q.pop_back();
                  else begin
                      m_uf = 1;
                      if (misaligned(tgt)) begin m_pc = TV; m_mis = 1; end
                      else m_pc = tgt;
                  end
            3'd4: m_pc = TV;
            3'd5: begin m_valid = 0; m_halted = 1; end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("pc_out",        64'(pc_out),        64'(m_pc));
        check_eq("pc_valid",      64'(pc_valid),      64'(m_valid));
        check_eq("ras_count",     64'(ras_count),     64'(exp_q.size()));
        check_eq("ras_overflow",  64'(ras_overflow),  64'(m_ovf));
        check_eq("ret_underflow", 64'(ret_underflow), 64'(m_uf));
        check_eq("misalign_err",  64'(misalign_err),  64'(m_mis));
        check_eq("halted",        64'(halted),        64'(m_halted));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic [2:0] sel,
                        input logic [31:0] tgt, input logic rdy);
        rst = r; pc_sel = sel; target_addr = tgt; pc_ready = rdy;
        @(posedge clk);
        model_edge(r, sel, tgt, rdy);
        @(negedge clk);
        check_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; pc_sel = 3'd0; target_addr = '0; pc_ready = 1'b0;
        @(negedge clk);
        step(1, 3'd0, 0, 1);
        step(1, 3'd0, 0, 1);
        check_eq("rst_pc", 64'(pc_out), 64'h0);
        check_eq("rst_valid", 64'(pc_valid), 64'h0);

        // boot cycle then three sequential advances
        step(0, 3'd0, 0, 1);
        check_eq("boot_valid", 64'(pc_valid), 64'h1);
        check_eq("boot_pc", 64'(pc_out), 64'h0);
        for (int i = 0; i < 3; i++) step(0, 3'd0, 0, 1);
        check_eq("seq3_pc", 64'(pc_out), 64'hC);

        // stall: branch ignored while not ready
        for (int i = 0; i < 4; i++) step(0, 3'd1, 32'h200, 0);
        check_eq("stall_pc", 64'(pc_out), 64'hC);
        step(0, 3'd1, 32'h200, 1);
        check_eq("branch_pc", 64'(pc_out), 64'h200);

        // call / seq / return
        step(0, 3'd1, 32'h40, 1);
        step(0, 3'd2, 32'h1000, 1);
        check_eq("call_cnt", 64'(ras_count), 64'h1);
        step(0, 3'd0, 0, 1);
        check_eq("call_seq_pc", 64'(pc_out), 64'h1004);
        step(0, 3'd3, 0, 1);
        check_eq("ret_pc", 64'(pc_out), 64'h44);
        check_eq("ret_cnt", 64'(ras_count), 64'h0);

        // nine calls overflow, nine returns underflow
        for (int i = 0; i < 9; i++) step(0, 3'd2, 32'h2000 + 32'(i) * 32'h10, 1);
        check_eq("ovf_cnt", 64'(ras_count), 64'h8);
        check_eq("ovf_flag", 64'(ras_overflow), 64'h1);
        for (int i = 0; i < 8; i++) step(0, 3'd3, 32'h0, 1);
        step(0, 3'd3, 32'h300, 1);
        check_eq("uf_pc", 64'(pc_out), 64'h300);
        check_eq("uf_pulse", 64'(ret_underflow), 64'h1);
        step(0, 3'd6, 0, 1);
        check_eq("uf_pulse_drop", 64'(ret_underflow), 64'h0);

        // misaligned targets
        step(0, 3'd2, 32'h500, 1);
        step(0, 3'd1, 32'h202, 1);
        check_eq("mis_pc", 64'(pc_out), 64'h100);
        check_eq("mis_pulse", 64'(misalign_err), 64'h1);
        step(0, 3'd2, 32'h203, 1);
        check_eq("mis_call_cnt", 64'(ras_count), 64'h1);

        // wrap, halt, reset out of halt
        step(0, 3'd1, 32'hFFFF_FFFC, 1);
        step(0, 3'd0, 0, 1);
        check_eq("wrap_pc", 64'(pc_out), 64'h0);
        step(0, 3'd5, 0, 1);
        check_eq("halt_flag", 64'(halted), 64'h1);
        for (int i = 0; i < 3; i++) step(0, 3'd1, 32'h80, 1);
        check_eq("halt_frozen", 64'(pc_out), 64'h0);
        step(1, 3'd1, 32'h80, 1);
        check_eq("halt_rst_state", 64'(dbg_state), 64'(S_BOOT));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [2:0]  sel;
            logic [31:0] tgt;
            int          k;
            r = ($urandom_range(0, m_halted ? 7 : 149) == 0);
            k = $urandom_range(0, 99);
            if (k < 2)       sel = 3'd5;
            else if (k < 35) sel = 3'd0;
            else if (k < 50) sel = 3'd1;
            else if (k < 70) sel = 3'd2;
            else if (k < 90) sel = 3'd3;
            else if (k < 95) sel = 3'd4;
            else             sel = 3'($urandom_range(6, 7));
            k = $urandom_range(0, 9);
            if (k == 0)      tgt = $urandom();
            else if (k == 1) tgt = 32'($urandom_range(0, 1023));
            else             tgt = 32'($urandom_range(0, 255)) * 32'(IB);
            step(r, sel, tgt, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
